// File: rtl/alu_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation select and FSM states.
package alu_pkg;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiply / restoring divide, one bit per RDY cycle.
// MUL and DIV share one accumulator (acc) and shift register (sh) pair.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int dw = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RDY,
  input  logic          start,
  input  logic          op,
  input  logic [dw-1:0] AI,
  input  logic [dw-1:0] BI,
  output logic          busy,
  output logic          done,
  output logic [dw-1:0] OUT_LO,
  output logic [dw-1:0] OUT_HI,
  output logic          Z,
  output logic          N,
  output logic          V
);

  localparam int              CW        = $clog2(dw + 1);
  localparam logic [CW-1:0]   CNT_LAST  = CW'(dw - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [dw:0]   acc_q, acc_d;
  logic [dw-1:0] sh_q, sh_d;
  logic [dw-1:0] b_q, b_d;
  op_e           op_q, op_d;
  logic [dw-1:0] out_lo_q, out_lo_d;
  logic [dw-1:0] out_hi_q, out_hi_d;
  logic          z_q, z_d;
  logic          n_q, n_d;
  logic          v_q, v_d;

  logic [dw:0]   mul_sum;
  logic [dw:0]   rem_sh;
  logic [dw:0]   diff;
  logic [dw:0]   iter_acc;
  logic [dw-1:0] iter_sh;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    b_d      = b_q;
    op_d     = op_q;
    out_lo_d = out_lo_q;
    out_hi_d = out_hi_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;

    // acc[dw] is always 0 between iterations, so the full acc can feed the adder.
    mul_sum = acc_q + (sh_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = {acc_q[dw-1:0], sh_q[dw-1]};
    // The partial remainder is below the divisor, so diff[dw] is exactly the borrow.
    diff    = rem_sh - {1'b0, b_q};

    if (op_q == OP_MUL) begin
      iter_acc = {1'b0, mul_sum[dw:1]};
      iter_sh  = {mul_sum[0], sh_q[dw-1:1]};
    end else begin
      iter_acc = diff[dw] ? rem_sh : diff;
      iter_sh  = {sh_q[dw-2:0], ~diff[dw]};
    end

    if (RDY) begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            acc_d   = '0;
            sh_d    = AI;
            b_d     = BI;
            op_d    = op_e'(op);
          end
        end
        RUN: begin
          acc_d = iter_acc;
          sh_d  = iter_sh;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = DONE;
            out_hi_d = iter_acc[dw-1:0];
            out_lo_d = iter_sh;
            if (op_q == OP_MUL) begin
              z_d = ~|{iter_acc[dw-1:0], iter_sh};
              n_d = iter_acc[dw-1];
              v_d = 1'b0;
            end else begin
              // Divide by zero falls out naturally: quotient all ones, remainder = dividend.
              z_d = ~|iter_sh;
              n_d = iter_sh[dw-1];
              v_d = ~|b_q;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      b_q      <= '0;
      op_q     <= OP_MUL;
      out_lo_q <= '0;
      out_hi_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      b_q      <= b_d;
      op_q     <= op_d;
      out_lo_q <= out_lo_d;
      out_hi_q <= out_hi_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign OUT_LO = out_lo_q;
  assign OUT_HI = out_hi_q;
  assign Z      = z_q;
  assign N      = n_q;
  assign V      = v_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv: a dw=16 and a dw=8 instance sharing clk, reset and RDY.
module tb_alu_muldiv;

  logic clk = 1'b0;
  logic reset, rdy;

  logic        start16, op16, busy16, done16, z16, n16, v16;
  logic [15:0] a16, b16, lo16, hi16;
  logic        start8, op8, busy8, done8, z8, n8, v8;
  logic [7:0]  a8, b8, lo8, hi8;

  int n_checks = 0;
  int n_fail   = 0;

  alu_muldiv #(.dw(16)) dut16 (
    .clk(clk), .reset(reset), .RDY(rdy), .start(start16), .op(op16),
    .AI(a16), .BI(b16), .busy(busy16), .done(done16),
    .OUT_LO(lo16), .OUT_HI(hi16), .Z(z16), .N(n16), .V(v16)
  );

  alu_muldiv #(.dw(8)) dut8 (
    .clk(clk), .reset(reset), .RDY(rdy), .start(start8), .op(op8),
    .AI(a8), .BI(b8), .busy(busy8), .done(done8),
    .OUT_LO(lo8), .OUT_HI(hi8), .Z(z8), .N(n8), .V(v8)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] res16();
    return {hi16, lo16, z16, n16, v16};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns in cycle 1 of the operation.
  task automatic start_op16(input logic o, input logic [15:0] a, input logic [15:0] b);
    start16 = 1'b1; op16 = o; a16 = a; b16 = b;
    tick();
    start16 = 1'b0;
  endtask

  task automatic wait_done16(input int c0, output int cyc);
    cyc = c0;
    while (!done16 && cyc < 200) begin
      tick();
      cyc++;
    end
    if (!done16) begin
      n_checks++; n_fail++;
      $display("FAIL timeout16: done never rose, waited %0d cycles", cyc);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rdy = 1'b0; start16 = 1'b1; start8 = 1'b0;
    op16 = 1'b0; a16 = 16'h1111; b16 = 16'h2222; op8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) tick();
    n_checks++;
    if ({busy16, done16} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ctl16: busy/done=%b required 00", {busy16, done16});
    end
    n_checks++;
    if (res16() !== 35'h0) begin
      n_fail++; $display("FAIL reset_res16: got %h required 0", res16());
    end
    n_checks++;
    if ({busy8, done8, hi8, lo8, z8, n8, v8} !== 21'h0) begin
      n_fail++; $display("FAIL reset8: got %h required 0", {busy8, done8, hi8, lo8, z8, n8, v8});
    end
    start16 = 1'b0; reset = 1'b0; rdy = 1'b1;
    tick();
  endtask

  task automatic test_mul();
    int cyc;
    start_op16(1'b0, 16'h1234, 16'h5678);
    wait_done16(1, cyc);
    n_checks++;
    if (cyc !== 17) begin
      n_fail++; $display("FAIL mul_latency: done at cycle %0d required 17", cyc);
    end
    n_checks++;
    if (res16() !== {16'h0626, 16'h0060, 3'b000}) begin
      n_fail++; $display("FAIL mul_1234x5678: got %h required %h", res16(), {16'h0626, 16'h0060, 3'b000});
    end
    tick();
    start_op16(1'b0, 16'hFFFF, 16'hFFFF);
    wait_done16(1, cyc);
    n_checks++;
    if (res16() !== {16'hFFFE, 16'h0001, 3'b010}) begin
      n_fail++; $display("FAIL mul_ffffxffff: got %h required %h", res16(), {16'hFFFE, 16'h0001, 3'b010});
    end
    tick();
    start_op16(1'b0, 16'h0000, 16'hABCD);
    wait_done16(1, cyc);
    n_checks++;
    if (res16() !== {16'h0000, 16'h0000, 3'b100}) begin
      n_fail++; $display("FAIL mul_zero: got %h required %h", res16(), {16'h0000, 16'h0000, 3'b100});
    end
    tick();
  endtask

  task automatic test_div();
    int cyc;
    start_op16(1'b1, 16'hFFFF, 16'h0010);
    wait_done16(1, cyc);
    n_checks++;
    if (res16() !== {16'h000F, 16'h0FFF, 3'b000}) begin
      n_fail++; $display("FAIL div_ffff_10: got %h required %h", res16(), {16'h000F, 16'h0FFF, 3'b000});
    end
    tick();
    start_op16(1'b1, 16'h1234, 16'h0000);
    wait_done16(1, cyc);
    n_checks++;
    if (res16() !== {16'h1234, 16'hFFFF, 3'b011}) begin
      n_fail++; $display("FAIL div_by_zero: got %h required %h", res16(), {16'h1234, 16'hFFFF, 3'b011});
    end
    tick();
  endtask

  // Starts again in the first IDLE cycle after a completion.
  task automatic test_back_to_back();
    int cyc;
    start_op16(1'b1, 16'h0064, 16'h0007);
    wait_done16(1, cyc);
    n_checks++;
    if (res16() !== {16'h0002, 16'h000E, 3'b000}) begin
      n_fail++; $display("FAIL div_100_7: got %h required %h", res16(), {16'h0002, 16'h000E, 3'b000});
    end
    tick();
    start_op16(1'b0, 16'h00FF, 16'h0101);
    wait_done16(1, cyc);
    n_checks++;
    if (cyc !== 17 || res16() !== {16'h0000, 16'hFFFF, 3'b000}) begin
      n_fail++; $display("FAIL back_to_back: cycle %0d result %h required 17 %h", cyc, res16(), {16'h0000, 16'hFFFF, 3'b000});
    end
    tick();
  endtask

  task automatic test_rdy_stall();
    int cyc;
    start_op16(1'b0, 16'h1234, 16'h5678);
    cyc = 1;
    repeat (4) begin tick(); cyc++; end
    rdy = 1'b0;
    repeat (5) begin tick(); cyc++; end
    rdy = 1'b1;
    wait_done16(cyc, cyc);
    n_checks++;
    if (cyc !== 22) begin
      n_fail++; $display("FAIL stall_latency: done at cycle %0d required 22", cyc);
    end
    n_checks++;
    if (res16() !== {16'h0626, 16'h0060, 3'b000}) begin
      n_fail++; $display("FAIL stall_result: got %h required %h", res16(), {16'h0626, 16'h0060, 3'b000});
    end
    rdy = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({busy16, done16} !== 2'b01) begin
      n_fail++; $display("FAIL done_held: busy/done=%b required 01", {busy16, done16});
    end
    rdy = 1'b1;
    tick();
    n_checks++;
    if ({busy16, done16} !== 2'b00) begin
      n_fail++; $display("FAIL done_cleared: busy/done=%b required 00", {busy16, done16});
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    start_op16(1'b0, 16'h0003, 16'h0005);
    repeat (3) tick();
    start16 = 1'b1; op16 = 1'b1; a16 = 16'hBEEF; b16 = 16'h0001;
    tick();
    start16 = 1'b0;
    n_checks++;
    if (busy16 !== 1'b1) begin
      n_fail++; $display("FAIL busy_in_run: got %b required 1", busy16);
    end
    wait_done16(5, cyc);
    n_checks++;
    if (cyc !== 17 || res16() !== {16'h0000, 16'h000F, 3'b000}) begin
      n_fail++; $display("FAIL ignore_start: cycle %0d result %h required 17 %h", cyc, res16(), {16'h0000, 16'h000F, 3'b000});
    end
    tick();
  endtask

  task automatic test_reset_abort();
    bit seen_done = 1'b0;
    start_op16(1'b0, 16'h1234, 16'h5678);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if ({busy16, done16} !== 2'b00 || res16() !== 35'h0) begin
      n_fail++; $display("FAIL reset_abort: busy/done=%b result %h required 00 0", {busy16, done16}, res16());
    end
    repeat (20) begin
      tick();
      if (done16) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done || res16() !== 35'h0) begin
      n_fail++; $display("FAIL abort_no_done: done_seen=%b result %h required 0 0", seen_done, res16());
    end
  endtask

  task automatic test_reset_priority();
    reset = 1'b1; start16 = 1'b1; op16 = 1'b0; a16 = 16'h0002; b16 = 16'h0002;
    tick();
    reset = 1'b0; start16 = 1'b0;
    tick();
    n_checks++;
    if ({busy16, done16} !== 2'b00) begin
      n_fail++; $display("FAIL reset_priority: busy/done=%b required 00", {busy16, done16});
    end
  endtask

  task automatic test_dw8();
    int cyc;
    start8 = 1'b1; op8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 100) begin tick(); cyc++; end
    n_checks++;
    if (cyc !== 9) begin
      n_fail++; $display("FAIL dw8_latency: done at cycle %0d required 9", cyc);
    end
    n_checks++;
    if ({hi8, lo8, z8, n8, v8} !== {8'hFE, 8'h01, 3'b010}) begin
      n_fail++; $display("FAIL dw8_mul: got %h required %h", {hi8, lo8, z8, n8, v8}, {8'hFE, 8'h01, 3'b010});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_rdy_stall();
    test_ignore_start();
    test_reset_abort();
    test_reset_priority();
    test_dw8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
